// File: rtl/regfile_mp.sv
// regfile_mp: CR16 register file with one write port, P_READ_PORTS registered
// read ports with write-to-read bypass, an optional hardwired-zero register 0,
// and a per-register busy scoreboard for pending writebacks.
module regfile_mp #(
    parameter  int P_REG_WIDTH  = 16,
    parameter  int P_FILE_WIDTH = 16,
    parameter  int P_READ_PORTS = 2,
    parameter  int P_ZERO_REG   = 0,
    localparam int AW           = $clog2(P_FILE_WIDTH)
) (
    input  logic                                      I_CLK,
    input  logic                                      I_RESET,
    input  logic                                      I_WRITE_ENABLE,
    input  logic [AW-1:0]                             I_WRITE_ADDR,
    input  logic [P_REG_WIDTH-1:0]                    I_WRITE_DATA,
    input  logic                                      I_RESERVE_ENABLE,
    input  logic [AW-1:0]                             I_RESERVE_ADDR,
    input  logic [P_READ_PORTS-1:0]                   I_READ_ENABLE,
    input  logic [P_READ_PORTS-1:0][AW-1:0]           I_READ_ADDR,
    output logic [P_READ_PORTS-1:0][P_REG_WIDTH-1:0]  O_READ_DATA,
    output logic [P_READ_PORTS-1:0]                   O_READ_VALID,
    output logic [P_READ_PORTS-1:0]                   O_READ_BUSY,
    output logic [P_FILE_WIDTH-1:0]                   O_BUSY,
    output logic [P_FILE_WIDTH-1:0][P_REG_WIDTH-1:0]  O_REG_DATA
);

    logic [P_FILE_WIDTH-1:0][P_REG_WIDTH-1:0] regs_q, regs_d;
    logic [P_FILE_WIDTH-1:0]                  busy_q, busy_d;
    logic [P_READ_PORTS-1:0][P_REG_WIDTH-1:0] rdata_q, rdata_d;
    logic [P_READ_PORTS-1:0]                  rvalid_q, rvalid_d;
    logic [P_READ_PORTS-1:0]                  rbusy_q, rbusy_d;

    // Register 0 is not a storage slot when the hardwired-zero option is on.
    function automatic logic slot_ok(input int unsigned idx);
        return !((P_ZERO_REG != 0) && (idx == 0));
    endfunction

    // Next register/scoreboard state. Addresses are matched against every
    // implemented slot, so out-of-range addresses simply match nothing.
    // Reserve is applied after write so a same-cycle reservation wins.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int unsigned i = 0; i < P_FILE_WIDTH; i++) begin
            if (slot_ok(i)) begin
                if (I_WRITE_ENABLE && (I_WRITE_ADDR == AW'(i))) begin
                    regs_d[i] = I_WRITE_DATA;
                    busy_d[i] = 1'b0;
                end
                if (I_RESERVE_ENABLE && (I_RESERVE_ADDR == AW'(i))) begin
                    busy_d[i] = 1'b1;
                end
            end
        end
    end

    // Read ports sample the next-state file, which provides the bypass.
    // Disabled ports hold data/busy; unmatched addresses read as zero.
    always_comb begin
        rdata_d  = rdata_q;
        rbusy_d  = rbusy_q;
        rvalid_d = '0;
        for (int unsigned p = 0; p < P_READ_PORTS; p++) begin
            if (I_READ_ENABLE[p]) begin
                rvalid_d[p] = 1'b1;
                rdata_d[p]  = '0;
                rbusy_d[p]  = 1'b0;
                for (int unsigned i = 0; i < P_FILE_WIDTH; i++) begin
                    if (slot_ok(i) && (I_READ_ADDR[p] == AW'(i))) begin
                        rdata_d[p] = regs_d[i];
                        rbusy_d[p] = busy_d[i];
                    end
                end
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            regs_q   <= '0;
            busy_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= '0;
            rbusy_q  <= '0;
        end else begin
            regs_q   <= regs_d;
            busy_q   <= busy_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            rbusy_q  <= rbusy_d;
        end
    end

    assign O_READ_DATA  = rdata_q;
    assign O_READ_VALID = rvalid_q;
    assign O_READ_BUSY  = rbusy_q;
    assign O_BUSY       = busy_q;
    assign O_REG_DATA   = regs_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (default 16x2, and 12 regs x 3 ports
// with hardwired zero) share one stimulus stream and are checked against an
// array-based reference model every cycle.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst;
    logic we;
    logic [3:0] wa;
    logic [15:0] wd;
    logic res;
    logic [3:0] ra;
    logic [2:0] ren;
    logic [2:0][3:0] raddr;

    logic [1:0][15:0]  d0_rd;
    logic [1:0]        d0_rv, d0_rb;
    logic [15:0]       d0_busy;
    logic [15:0][15:0] d0_regs;
    logic [2:0][15:0]  d1_rd;
    logic [2:0]        d1_rv, d1_rb;
    logic [11:0]       d1_busy;
    logic [11:0][15:0] d1_regs;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_mp #(.P_REG_WIDTH(16), .P_FILE_WIDTH(16), .P_READ_PORTS(2), .P_ZERO_REG(0)) dut0 (
        .I_CLK(clk), .I_RESET(rst),
        .I_WRITE_ENABLE(we), .I_WRITE_ADDR(wa), .I_WRITE_DATA(wd),
        .I_RESERVE_ENABLE(res), .I_RESERVE_ADDR(ra),
        .I_READ_ENABLE(ren[1:0]), .I_READ_ADDR(raddr[1:0]),
        .O_READ_DATA(d0_rd), .O_READ_VALID(d0_rv), .O_READ_BUSY(d0_rb),
        .O_BUSY(d0_busy), .O_REG_DATA(d0_regs)
    );

    regfile_mp #(.P_REG_WIDTH(16), .P_FILE_WIDTH(12), .P_READ_PORTS(3), .P_ZERO_REG(1)) dut1 (
        .I_CLK(clk), .I_RESET(rst),
        .I_WRITE_ENABLE(we), .I_WRITE_ADDR(wa), .I_WRITE_DATA(wd),
        .I_RESERVE_ENABLE(res), .I_RESERVE_ADDR(ra),
        .I_READ_ENABLE(ren), .I_READ_ADDR(raddr),
        .O_READ_DATA(d1_rd), .O_READ_VALID(d1_rv), .O_READ_BUSY(d1_rb),
        .O_BUSY(d1_busy), .O_REG_DATA(d1_regs)
    );

    // Reference model: plain arrays per instance.
    int          nregs  [2] = '{16, 12};
    int          nports [2] = '{2, 3};
    int          zero   [2] = '{0, 1};
    logic [15:0] m_reg  [2][16];
    bit          m_busy [2][16];
    logic [15:0] m_rd   [2][3];
    bit          m_rv   [2][3];
    bit          m_rb   [2][3];

    function automatic bit m_ok(int k, int a);
        return (a < nregs[k]) && !(zero[k] != 0 && a == 0);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) begin
                m_reg[k][i]  = 16'h0;
                m_busy[k][i] = 1'b0;
            end
            for (int p = 0; p < 3; p++) begin
                m_rd[k][p] = 16'h0;
                m_rv[k][p] = 1'b0;
                m_rb[k][p] = 1'b0;
            end
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            if (we && m_ok(k, int'(wa))) begin
                m_reg[k][wa]  = wd;
                m_busy[k][wa] = 1'b0;
            end
            if (res && m_ok(k, int'(ra))) m_busy[k][ra] = 1'b1;
            for (int p = 0; p < nports[k]; p++) begin
                if (ren[p]) begin
                    m_rv[k][p] = 1'b1;
                    m_rd[k][p] = m_ok(k, int'(raddr[p])) ? m_reg[k][raddr[p]] : 16'h0;
                    m_rb[k][p] = m_ok(k, int'(raddr[p])) ? m_busy[k][raddr[p]] : 1'b0;
                end else begin
                    m_rv[k][p] = 1'b0;
                end
            end
        end
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [15:0] eb;
        for (int p = 0; p < 2; p++) begin
            check_eq($sformatf("d0.rv[%0d]", p), 32'(d0_rv[p]), 32'(m_rv[0][p]));
            check_eq($sformatf("d0.rd[%0d]", p), 32'(d0_rd[p]), 32'(m_rd[0][p]));
            check_eq($sformatf("d0.rb[%0d]", p), 32'(d0_rb[p]), 32'(m_rb[0][p]));
        end
        for (int p = 0; p < 3; p++) begin
            check_eq($sformatf("d1.rv[%0d]", p), 32'(d1_rv[p]), 32'(m_rv[1][p]));
            check_eq($sformatf("d1.rd[%0d]", p), 32'(d1_rd[p]), 32'(m_rd[1][p]));
            check_eq($sformatf("d1.rb[%0d]", p), 32'(d1_rb[p]), 32'(m_rb[1][p]));
        end
        eb = '0;
        for (int i = 0; i < 16; i++) begin
            eb[i] = m_busy[0][i];
            check_eq($sformatf("d0.reg[%0d]", i), 32'(d0_regs[i]), 32'(m_reg[0][i]));
        end
        check_eq("d0.busy", 32'(d0_busy), 32'(eb));
        eb = '0;
        for (int i = 0; i < 12; i++) begin
            eb[i] = m_busy[1][i];
            check_eq($sformatf("d1.reg[%0d]", i), 32'(d1_regs[i]), 32'(m_reg[1][i]));
        end
        check_eq("d1.busy", 32'(d1_busy), 32'(eb[11:0]));
    endtask

    // One clock edge: advance the model, then sample just after the edge.
    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else     model_update();
        #1;
        check_all();
    endtask

    task automatic idle();
        we = 1'b0; wa = '0; wd = '0; res = 1'b0; ra = '0; ren = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        raddr = '0;
        model_reset();
        #1;
        check_all();
        cycle();
        cycle();
        rst = 1'b0;

        // Populate some state so the mid-cycle reset has something to clear.
        for (int i = 0; i < 8; i++) begin
            we = 1'b1; wa = 4'(i); wd = 16'h1000 + 16'(i);
            res = 1'b1; ra = 4'(i + 8);
            ren = 3'b111; raddr = '{4'(i), 4'(i + 1), 4'(i + 2)};
            cycle();
        end

        // Asynchronous reset mid-cycle, with a read pending across the edge.
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        check_eq("async.valid", 32'(d0_rv), 32'h0);
        cycle();
        rst = 1'b0;
        idle();

        // Read r5 right after release.
        ren = 3'b001; raddr[0] = 4'd5;
        cycle();
        check_eq("rst.rd5.valid", 32'(d0_rv[0]), 32'h1);
        check_eq("rst.rd5.data", 32'(d0_rd[0]), 32'h0);
        check_eq("rst.rd5.busy", 32'(d0_rb[0]), 32'h0);

        // Write then read on two ports.
        idle(); we = 1'b1; wa = 4'd3; wd = 16'hBEEF;
        cycle();
        idle(); ren = 3'b011; raddr[0] = 4'd3; raddr[1] = 4'd3;
        cycle();
        check_eq("wr.p0", 32'(d0_rd[0]), 32'hBEEF);
        check_eq("wr.p1", 32'(d0_rd[1]), 32'hBEEF);
        check_eq("wr.valid", 32'(d0_rv), 32'h3);

        // Bypass of a same-cycle write.
        idle(); we = 1'b1; wa = 4'd7; wd = 16'h5555;
        cycle();
        idle(); we = 1'b1; wa = 4'd7; wd = 16'h1234; ren = 3'b010; raddr[1] = 4'd7;
        cycle();
        check_eq("bypass.p1", 32'(d0_rd[1]), 32'h1234);

        // Scoreboard.
        idle(); res = 1'b1; ra = 4'd4;
        cycle();
        check_eq("rsv.busy4", 32'(d0_busy[4]), 32'h1);
        idle(); ren = 3'b001; raddr[0] = 4'd4;
        cycle();
        check_eq("rsv.rdbusy", 32'(d0_rb[0]), 32'h1);
        idle(); we = 1'b1; wa = 4'd4; wd = 16'h0042;
        cycle();
        check_eq("wb.busy4", 32'(d0_busy[4]), 32'h0);
        idle(); we = 1'b1; wa = 4'd4; wd = 16'h0099; res = 1'b1; ra = 4'd4;
        cycle();
        check_eq("both.busy4", 32'(d0_busy[4]), 32'h1);
        check_eq("both.data4", 32'(d0_regs[4]), 32'h0099);

        // Hardwired zero register on the second instance.
        idle(); we = 1'b1; wa = 4'd0; wd = 16'hFFFF; res = 1'b1; ra = 4'd0;
        ren = 3'b100; raddr[2] = 4'd0;
        cycle();
        check_eq("z.reg0", 32'(d1_regs[0]), 32'h0);
        check_eq("z.busy0", 32'(d1_busy[0]), 32'h0);
        check_eq("z.rd0", 32'(d1_rd[2]), 32'h0);
        check_eq("z.rv", 32'(d1_rv[2]), 32'h1);
        check_eq("nz.reg0", 32'(d0_regs[0]), 32'hFFFF);

        // Out-of-range address on the 12-entry instance.
        idle(); ren = 3'b001; raddr[0] = 4'd3;
        cycle();
        idle(); we = 1'b1; wa = 4'd13; wd = 16'hAAAA; ren = 3'b001; raddr[0] = 4'd13;
        cycle();
        check_eq("oor.rd", 32'(d1_rd[0]), 32'h0);
        check_eq("oor.rv", 32'(d1_rv[0]), 32'h1);
        idle();
        cycle();
        check_eq("hold.rv", 32'(d1_rv[0]), 32'h0);
        check_eq("hold.rd", 32'(d1_rd[0]), 32'h0);
        check_eq("hold.d0rd", 32'(d0_rd[0]), 32'hAAAA);

        // Randomized traffic, biased toward address collisions.
        for (int n = 0; n < 400; n++) begin
            we    = 1'($urandom_range(0, 1));
            wa    = 4'($urandom_range(0, 15));
            wd    = 16'($urandom);
            res   = ($urandom_range(0, 2) == 0);
            ra    = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
            ren   = 3'($urandom);
            for (int p = 0; p < 3; p++)
                raddr[p] = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
